// File: rtl/set_value_editor_pkg.sv
// Shared definitions for the set-mode editor: one-hot edit states, field widths
// and the calendar helpers used by the field arithmetic.
package set_pkg;

   typedef logic [6:0] state_t;

   localparam state_t L1 = 7'b0000001;  // idle
   localparam state_t L2 = 7'b0000010;  // hour
   localparam state_t L3 = 7'b0000100;  // minute
   localparam state_t L4 = 7'b0001000;  // second
   localparam state_t L5 = 7'b0010000;  // year
   localparam state_t L6 = 7'b0100000;  // month
   localparam state_t L7 = 7'b1000000;  // day

   localparam int HOUR_W  = 5;
   localparam int MIN_W   = 6;
   localparam int SEC_W   = 6;
   localparam int YEAR_W  = 7;
   localparam int MONTH_W = 4;
   localparam int DAY_W   = 5;

   function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                       input logic leap);
      logic [DAY_W-1:0] dim;
      case (month)
         4'd2:                      dim = leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
         default:                   dim = 5'd31;
      endcase
      return dim;
   endfunction

   // Years 2000..2099 only, so divisibility by 4 is the whole leap rule.
   function automatic logic [DAY_W-1:0] clamp_day(input logic [DAY_W-1:0]   day,
                                                   input logic [MONTH_W-1:0] month,
                                                   input logic [YEAR_W-1:0]  year);
      logic [DAY_W-1:0] dim;
      dim = days_in_month(month, year[1:0] == 2'b00);
      return (day > dim) ? dim : day;
   endfunction

   function automatic logic [6:0] step_field(input logic [6:0] value,
                                              input logic [6:0] lo,
                                              input logic [6:0] hi,
                                              input logic       up);
      logic [6:0] res;
      if (up)
         res = (value >= hi) ? lo : value + 7'd1;
      else
         res = (value <= lo) ? hi : value - 7'd1;
      return res;
   endfunction

endpackage

// File: rtl/set_value_editor_if.sv
// Bundle between the set-mode sequencer/timekeeper side (master) and the editor (slave).
interface set_value_editor_if;
   import set_pkg::*;

   state_t               CURRENT_STATE;
   logic                 UP;
   logic                 DOWN;
   logic [HOUR_W-1:0]    CUR_HOUR;
   logic [MIN_W-1:0]     CUR_MIN;
   logic [SEC_W-1:0]     CUR_SEC;
   logic [YEAR_W-1:0]    CUR_YEAR;
   logic [MONTH_W-1:0]   CUR_MONTH;
   logic [DAY_W-1:0]     CUR_DAY;
   logic [HOUR_W-1:0]    SET_HOUR;
   logic [MIN_W-1:0]     SET_MIN;
   logic [SEC_W-1:0]     SET_SEC;
   logic [YEAR_W-1:0]    SET_YEAR;
   logic [MONTH_W-1:0]   SET_MONTH;
   logic [DAY_W-1:0]     SET_DAY;
   logic                 EDITING;
   logic                 COMMIT;

   modport master (
      output CURRENT_STATE, UP, DOWN,
      output CUR_HOUR, CUR_MIN, CUR_SEC, CUR_YEAR, CUR_MONTH, CUR_DAY,
      input  SET_HOUR, SET_MIN, SET_SEC, SET_YEAR, SET_MONTH, SET_DAY,
      input  EDITING, COMMIT
   );

   modport slave (
      input  CURRENT_STATE, UP, DOWN,
      input  CUR_HOUR, CUR_MIN, CUR_SEC, CUR_YEAR, CUR_MONTH, CUR_DAY,
      output SET_HOUR, SET_MIN, SET_SEC, SET_YEAR, SET_MONTH, SET_DAY,
      output EDITING, COMMIT
   );

endinterface

// File: rtl/set_value_editor_step_repeat.sv
// Button step generator: one step on the rising edge, then auto-repeat after a long
// hold. CLR restarts the hold timing and suppresses any step in that cycle.
module step_repeat #(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic BTN,
   input  logic CLR,
   output logic STEP
);

   localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic             btn_prev_reg;
   logic             repeating_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] target;
   logic             cnt_hit;

   // First interval is the hold time, every later one the repeat time.
   assign target  = repeating_reg ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES);
   assign cnt_hit = (cnt_reg == target);
   assign STEP    = BTN & ~CLR & (~btn_prev_reg | cnt_hit);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         btn_prev_reg  <= 1'b0;
         repeating_reg <= 1'b0;
         cnt_reg       <= '0;
      end else begin
         btn_prev_reg <= BTN;
         if (CLR || !BTN) begin
            cnt_reg       <= '0;
            repeating_reg <= 1'b0;
         end else if (!btn_prev_reg || cnt_hit) begin
            cnt_reg       <= CNT_W'(1);
            repeating_reg <= btn_prev_reg;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/set_value_editor.sv
// Time/date field editor: snapshots the live values on entry, steps the selected field,
// pulses COMMIT on exit. Define SET_DOWN_EN to enable DOWN stepping.
module set_value_editor
   import set_pkg::*;
#(
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic               CLK,
   input  logic               RESET_N,
   set_value_editor_if.slave  bus
);

   state_t               cur_state;
   state_t               prev_state_reg;
   logic                 state_change;
   logic                 clr_up;
   logic                 step_up;
   logic                 step_down;
   logic                 apply;
   logic                 commit_reg;

   logic [HOUR_W-1:0]    hour_reg,  hour_next;
   logic [MIN_W-1:0]     min_reg,   min_next;
   logic [SEC_W-1:0]     sec_reg,   sec_next;
   logic [YEAR_W-1:0]    year_reg,  year_next;
   logic [MONTH_W-1:0]   month_reg, month_next;
   logic [DAY_W-1:0]     day_reg,   day_next;

   assign cur_state    = $onehot(bus.CURRENT_STATE) ? bus.CURRENT_STATE : L1;
   assign state_change = (cur_state != prev_state_reg);

`ifdef SET_DOWN_EN
   logic both_pressed;
   assign both_pressed = bus.UP & bus.DOWN;
   assign clr_up       = state_change | both_pressed;

   step_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_down_step (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .BTN     (bus.DOWN),
      .CLR     (clr_up),
      .STEP    (step_down)
   );
`else
   wire unused_down = bus.DOWN;
   assign clr_up    = state_change;
   assign step_down = 1'b0;
`endif

   step_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_up_step (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .BTN     (bus.UP),
      .CLR     (clr_up),
      .STEP    (step_up)
   );

   // Steps only land in a settled edit state; entry and field-change cycles are excluded.
   assign apply = (step_up | step_down) & ~state_change & (cur_state != L1);

   always_comb begin
      hour_next  = hour_reg;
      min_next   = min_reg;
      sec_next   = sec_reg;
      year_next  = year_reg;
      month_next = month_reg;
      day_next   = day_reg;
      if (apply) begin
         case (cur_state)
            L2: hour_next = HOUR_W'(step_field(7'(hour_reg), 7'd0, 7'd23, step_up));
            L3: min_next  = MIN_W'(step_field(7'(min_reg), 7'd0, 7'd59, step_up));
            L4: sec_next  = SEC_W'(step_field(7'(sec_reg), 7'd0, 7'd59, step_up));
            L5: begin
               year_next = YEAR_W'(step_field(7'(year_reg), 7'd0, 7'd99, step_up));
               day_next  = clamp_day(day_reg, month_reg, year_next);
            end
            L6: begin
               month_next = MONTH_W'(step_field(7'(month_reg), 7'd1, 7'd12, step_up));
               day_next   = clamp_day(day_reg, month_next, year_reg);
            end
            L7: day_next = DAY_W'(step_field(7'(day_reg), 7'd1,
                                             7'(days_in_month(month_reg, year_reg[1:0] == 2'b00)),
                                             step_up));
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         prev_state_reg <= L1;
         commit_reg     <= 1'b0;
         hour_reg       <= '0;
         min_reg        <= '0;
         sec_reg        <= '0;
         year_reg       <= '0;
         month_reg      <= MONTH_W'(1);
         day_reg        <= DAY_W'(1);
      end else begin
         prev_state_reg <= cur_state;
         commit_reg     <= (prev_state_reg != L1) && (cur_state == L1);
         if ((prev_state_reg == L1) && (cur_state != L1)) begin
            hour_reg  <= bus.CUR_HOUR;
            min_reg   <= bus.CUR_MIN;
            sec_reg   <= bus.CUR_SEC;
            year_reg  <= bus.CUR_YEAR;
            month_reg <= bus.CUR_MONTH;
            day_reg   <= bus.CUR_DAY;
         end else begin
            hour_reg  <= hour_next;
            min_reg   <= min_next;
            sec_reg   <= sec_next;
            year_reg  <= year_next;
            month_reg <= month_next;
            day_reg   <= day_next;
         end
      end
   end

   assign bus.SET_HOUR  = hour_reg;
   assign bus.SET_MIN   = min_reg;
   assign bus.SET_SEC   = sec_reg;
   assign bus.SET_YEAR  = year_reg;
   assign bus.SET_MONTH = month_reg;
   assign bus.SET_DAY   = day_reg;
   assign bus.EDITING   = (prev_state_reg != L1);
   assign bus.COMMIT    = commit_reg;

endmodule
